// File: rtl/prog_seq_ctrl_if.sv
`timescale 1ns/1ps
// prog_seq_ctrl_if: host program stream and register dump stream of prog_seq_ctrl.
// master = host/consumer side, slave = controller side.
interface prog_seq_ctrl_if;
  logic        h_valid;
  logic        h_ready;
  logic [31:0] h_data;
  logic        h_last;
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_data;
  logic [3:0]  d_idx;

  modport master (
    output h_valid, h_data, h_last, d_ready,
    input  h_ready, d_valid, d_data, d_idx
  );

  modport slave (
    input  h_valid, h_data, h_last, d_ready,
    output h_ready, d_valid, d_data, d_idx
  );
endinterface

// File: rtl/prog_seq_ctrl.sv
`timescale 1ns/1ps
// prog_seq_ctrl: streams a host program into instruction memory, runs the
// processor for run_len cycles, then dumps the register file word by word.
// Optional macro CC_DUMP_EN appends the condition codes as a final dump word.
module prog_seq_ctrl #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned NREG       = 8,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                  clock,
  input  logic                  rst_n,
  prog_seq_ctrl_if.slave        bus,
  input  logic                  start,
  input  logic [15:0]           run_len,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic                  err,
  output logic [31:0]           addr,
  output logic                  wr,
  output logic [31:0]           wdata,
  output logic                  working,
  output logic [3:0]            rID,
  input  logic [31:0]           rdata,
  input  logic [2:0]            cc
);

  localparam int unsigned PW       = $clog2(IMEM_DEPTH + 1);
  localparam logic [3:0]  LAST_IDX = 4'(NREG - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_SETTLE, S_DUMP_SEL, S_DUMP_WAIT, S_DUMP_OUT, S_FIN
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_prog_len;
  logic [15:0]   r_run_cnt;
  logic [1:0]    r_lat_cnt;
  logic [3:0]    r_idx;
  logic          r_h_ready, r_busy, r_done, r_ovf, r_err, r_wr, r_working;
  logic [31:0]   r_addr, r_wdata, r_d_data;
  logic [3:0]    r_rid, r_d_idx;
  logic          r_d_valid;

`ifdef CC_DUMP_EN
  logic [2:0]    r_cc;
`else
  logic          w_unused_cc;
  assign w_unused_cc = ^cc;
`endif

  logic          w_accept;
  logic          w_room;
  logic [PW-1:0] w_written;
  logic          w_cap;

  assign w_accept  = bus.h_valid & r_h_ready;
  assign w_room    = (r_wptr < PW'(IMEM_DEPTH));
  assign w_written = w_room ? r_wptr + PW'(1) : r_wptr;
  assign w_cap     = ((r_state == S_DUMP_SEL) && (RD_LAT == 0)) ||
                     ((r_state == S_DUMP_WAIT) && (r_lat_cnt == 2'd0));

  // Sequencer FSM: program load, run window, register dump, completion.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wptr     <= '0;
      r_prog_len <= '0;
      r_run_cnt  <= '0;
      r_lat_cnt  <= '0;
      r_idx      <= '0;
      r_h_ready  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_err      <= 1'b0;
      r_wr       <= 1'b0;
      r_working  <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rid      <= 4'hF;
      r_d_valid  <= 1'b0;
      r_d_data   <= '0;
      r_d_idx    <= '0;
`ifdef CC_DUMP_EN
      r_cc       <= '0;
`endif
    end else begin
      r_wr   <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_h_ready <= 1'b1;
          if (w_accept) begin
            // first word of a new program clears the previous overflow
            if (r_wptr == '0) r_ovf <= 1'b0;
            if (w_room) begin
              r_addr  <= 32'(r_wptr);
              r_wdata <= bus.h_data;
              r_wr    <= 1'b1;
              r_wptr  <= r_wptr + PW'(1);
            end else begin
              r_ovf <= 1'b1;
            end
            if (bus.h_last) begin
              r_prog_len <= w_written;
              r_wptr     <= '0;
            end
          end else if (start) begin
            if (r_prog_len == '0) begin
              r_err <= 1'b1;
            end else begin
              r_run_cnt <= run_len;
              r_h_ready <= 1'b0;
              r_busy    <= 1'b1;
              if (run_len == 16'd0) begin
                r_state <= S_SETTLE;
              end else begin
                r_working <= 1'b1;
                r_state   <= S_RUN;
              end
            end
          end
        end
        S_RUN: begin
          r_run_cnt <= r_run_cnt - 16'd1;
          if (r_run_cnt == 16'd1) begin
            r_working <= 1'b0;
            r_state   <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          r_rid   <= 4'd0;
          r_idx   <= 4'd0;
          r_state <= S_DUMP_SEL;
        end
        S_DUMP_SEL, S_DUMP_WAIT: begin
          if (w_cap) begin
            r_d_data  <= rdata;
            r_d_idx   <= r_idx;
            r_d_valid <= 1'b1;
            r_state   <= S_DUMP_OUT;
`ifdef CC_DUMP_EN
            if (r_idx == LAST_IDX) r_cc <= cc;
`endif
          end else if (r_state == S_DUMP_SEL) begin
            r_lat_cnt <= 2'(RD_LAT - 1);
            r_state   <= S_DUMP_WAIT;
          end else begin
            r_lat_cnt <= r_lat_cnt - 2'd1;
          end
        end
        S_DUMP_OUT: begin
          if (bus.d_ready) begin
            r_d_valid <= 1'b0;
            if (r_idx < LAST_IDX) begin
              r_idx   <= r_idx + 4'd1;
              r_rid   <= r_idx + 4'd1;
              r_state <= S_DUMP_SEL;
            end
`ifdef CC_DUMP_EN
            // cc word follows the last register; r_idx==NREG marks it sent
            else if (r_idx == LAST_IDX) begin
              r_idx     <= 4'(NREG);
              r_d_valid <= 1'b1;
              r_d_data  <= {29'b0, r_cc};
              r_d_idx   <= 4'(NREG);
            end
`endif
            else begin
              r_rid   <= 4'hF;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_FIN;
            end
          end
        end
        S_FIN: begin
          r_h_ready <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.h_ready = r_h_ready;
  assign bus.d_valid = r_d_valid;
  assign bus.d_data  = r_d_data;
  assign bus.d_idx   = r_d_idx;
  assign busy        = r_busy;
  assign done        = r_done;
  assign ovf         = r_ovf;
  assign err         = r_err;
  assign addr        = r_addr;
  assign wr          = r_wr;
  assign wdata       = r_wdata;
  assign working     = r_working;
  assign rID         = r_rid;

endmodule
